dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the MIPS core's data-memory port. It accepts one load/store request at a time, inserts a fixed number of wait states, and returns a one-cycle `ready` pulse. Stores are committed with byte/halfword lane handling; load data is sign- or zero-extended. It replaces the zero-latency data memory so the core's stall logic can be exercised against a realistic multi-cycle memory.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words in the internal RAM; must be a power of 2 and ≥ 4.
- `WAIT_STATES`, 2: cycles between acceptance and the `ready` cycle, minus 1; legal range 0–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; 0 sampled at a rising edge resets the block.
- `req` in 1: request valid; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `uns` in 1: 1 = zero-extend load data, 0 = sign-extend; ignored for word loads and stores.
- `adr` in 32: byte address.
- `wd` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rd` out 32: load result; valid when `ready`=1 and `we` was 0.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: asserted only together with `ready`; marks a failed request.
- `busy` out 1: 1 in WAIT and DONE.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - `req`=1 latches `we`, `size`, `uns`, `adr`, `wd` and loads the wait counter with `WAIT_STATES`.
  - If `WAIT_STATES`=0, go to DONE; otherwise go to WAIT.
  - `req`=0: remain in IDLE.
- WAIT: decrement the counter each cycle; go to DONE on the cycle the counter reaches 1.
- DONE: `ready`=1 for exactly this cycle, then return to IDLE.
- `req` is ignored in WAIT and DONE, including the DONE cycle. A new request is accepted one cycle after the `ready` pulse at the earliest.
- Error when any of these hold; error is evaluated on latched values:
  - `size`=11
  - halfword with `adr[0]`=1
  - word with `adr[1:0]`≠0
  - word index `adr[31:2]` ≥ `DEPTH_WORDS`
- On error: `err`=1 with `ready`, no RAM write, `rd`=0.
- Little-endian lanes: byte lane n = bits [8n+7:8n], selected by `adr[1:0]`.
  - Store byte writes `wd[7:0]` to lane `adr[1:0]` only.
  - Store half writes `wd[15:0]` to lanes {2·`adr[1]`+1, 2·`adr[1]`}.
  - Store word writes all four lanes. Other lanes are unchanged.
- Loads extract the addressed byte/half and right-align it.
  - `uns`=0: replicate the top bit into [31:8] or [31:16].
  - `uns`=1: fill with zeros.
- Store commit: the RAM is written at the rising edge ending the DONE cycle. A load issued immediately afterwards sees the new data.
- `rd` holds its last value until the next completed load or error. Stores do not change `rd`.
- RAM contents are not affected by reset and are undefined after power-up.

## Timing
- Reset values: `ready`=0, `err`=0, `busy`=0, `rd`=0, state=IDLE, counter=0.
- Latency: if the request is accepted in cycle t, then `ready`=1 in cycle t+1+`WAIT_STATES`; `busy`=1 from t+1 through that cycle.
- Throughput: one request per `WAIT_STATES`+2 cycles maximum.
- `rd`, `err`, `ready` and `busy` are registered outputs, with no combinational path from inputs.
- Reset asserted in WAIT or DONE:
  - Next state is IDLE and the pending store is discarded (no RAM write).
  - `ready` and `err` are 0 the following cycle.
  - `rd` returns to 0.
- Reset and `req` in the same cycle: reset wins; the request is dropped.
- Inputs other than `req` need not be held after the acceptance cycle.

## Test plan
- Reset, then with `WAIT_STATES`=2: store word 0xDEADBEEF @0x10 accepted in cycle 5 → `ready` in cycle 8, `err`=0. Load word @0x10 → `rd`=0xDEADBEEF.
- Store byte 0x80 @0x13 over 0x11223344, then load byte @0x13: `uns`=0 → `rd`=0xFFFFFF80; `uns`=1 → `rd`=0x00000080. Load word @0x10 → 0x80223344.
- Misaligned cases each give `ready`+`err`=1, `rd`=0, and memory unchanged:
  - half @0x21
  - word @0x22
  - `size`=11
  - word @(`DEPTH_WORDS`·4)
- `req` held high continuously → acceptances exactly `WAIT_STATES`+2 cycles apart. Requests presented during WAIT/DONE are not executed.
- Reset pulled low during WAIT of a store of 0x12345678 @0x30 (old value 0) → no `ready`. A later load @0x30 returns 0.
- `WAIT_STATES`=0 build: store half 0xBEEF @0x42 then load half @0x42 `uns`=0 → `ready` one cycle after each acceptance, `rd`=0xFFFFBEEF.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and the
// multi-cycle memory responder (slave).
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, size, uns, adr, wd,
        input  rd, ready, err, busy
    );

    modport slave (
        input  req, we, size, uns, adr, wd,
        output rd, ready, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed wait states,
// one-cycle ready pulse, byte/half lane stores and sign/zero-extended loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        accept_s;
    logic        req_err_s;
    logic [31:0] rd_word_s;
    logic [31:0] load_data_s;
    logic [3:0]  wr_be_s;
    logic [31:0] wr_data_s;
    logic        wr_en_s;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Request capture: the _d copies hold the request being accepted, so error and
    // load evaluation below always work on the latched view.
    always_comb begin
        accept_s = (state_q == ST_IDLE) && bus.req;
        if (accept_s) begin
            we_d   = bus.we;
            size_d = bus.size;
            uns_d  = bus.uns;
            adr_d  = bus.adr;
            wd_d   = bus.wd;
        end else begin
            we_d   = we_q;
            size_d = size_q;
            uns_d  = uns_q;
            adr_d  = adr_q;
            wd_d   = wd_q;
        end
    end

    // Error decode and load lane extraction on the latched request.
    always_comb begin
        req_err_s = (size_d == 2'b11) ||
                    ((size_d == 2'b01) && adr_d[0]) ||
                    ((size_d == 2'b10) && (adr_d[1:0] != 2'b00)) ||
                    (adr_d[31:2] >= 30'(DEPTH_WORDS));
        rd_word_s   = mem[adr_d[AW+1:2]];
        load_data_s = load_extend(rd_word_s, size_d, adr_d[1:0], uns_d);
    end

    // Store lane enables and right-aligned data replicated across the lanes.
    always_comb begin
        case (size_q)
            2'b00: begin
                wr_be_s   = 4'b0001 << adr_q[1:0];
                wr_data_s = {4{wd_q[7:0]}};
            end
            2'b01: begin
                wr_be_s   = adr_q[1] ? 4'b1100 : 4'b0011;
                wr_data_s = {2{wd_q[15:0]}};
            end
            2'b10: begin
                wr_be_s   = 4'b1111;
                wr_data_s = wd_q;
            end
            default: begin
                wr_be_s   = 4'b0000;
                wr_data_s = 32'h0000_0000;
            end
        endcase
        wr_en_s = (state_q == ST_DONE) && reset && we_q && !err_q;
    end

    // Sequencing and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        if (state_d == ST_DONE) begin
            err_d = req_err_s;
            if (req_err_s) begin
                rd_d = 32'h0000_0000;
            end else if (!we_d) begin
                rd_d = load_data_s;
            end else begin
                rd_d = rd_q;
            end
        end else begin
            err_d = 1'b0;
            rd_d  = rd_q;
        end
    end

    // State and output registers; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            adr_q   <= 32'h0000_0000;
            wd_q    <= 32'h0000_0000;
            rd_q    <= 32'h0000_0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            adr_q   <= adr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // RAM byte-lane write at the end of the DONE cycle; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && wr_be_s[i]) begin
                mem[adr_q[AW+1:2]][8*i +: 8] <= wr_data_s[8*i +: 8];
            end
        end
    end

    assign bus.rd    = rd_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance
// share one stimulus driver, selected by sel.
module tb_dmem_responder;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        req_s, we_s, uns_s;
    logic [1:0]  size_s;
    logic [31:0] adr_s, wd_s;
    int          ws;

    dmem_responder_if bus2();
    dmem_responder_if bus0();

    assign bus2.req = req_s & ~sel;
    assign bus0.req = req_s & sel;
    assign bus2.we = we_s;     assign bus0.we = we_s;
    assign bus2.size = size_s; assign bus0.size = size_s;
    assign bus2.uns = uns_s;   assign bus0.uns = uns_s;
    assign bus2.adr = adr_s;   assign bus0.adr = adr_s;
    assign bus2.wd = wd_s;     assign bus0.wd = wd_s;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus2)
    );
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    logic [31:0] rd_o;
    logic        rdy_o, err_o, busy_o;
    assign rd_o   = sel ? bus0.rd    : bus2.rd;
    assign rdy_o  = sel ? bus0.ready : bus2.ready;
    assign err_o  = sel ? bus0.err   : bus2.err;
    assign busy_o = sel ? bus0.busy  : bus2.busy;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
        int          rdy_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Response monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        check_eq("err_only_with_ready", {31'd0, err_o & ~rdy_o}, 32'd0);
        if (rdy_o) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_ready", {31'd0, rdy_o}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("ready_cycle", 32'(cyc), 32'(mon_e.rdy_cyc));
                check_eq("err", {31'd0, err_o}, {31'd0, mon_e.err});
                check_eq("busy_at_ready", {31'd0, busy_o}, 32'd1);
                if (mon_e.chk_rd) check_eq("rd", rd_o, mon_e.rd);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || busy_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("idle_timeout_busy", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] adr, input logic [31:0] wd,
                          input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
        exp_t e;
        wait_idle();
        req_s = 1'b1; we_s = we; size_s = size; uns_s = uns; adr_s = adr; wd_s = wd;
        e.rd = exp_rd; e.err = exp_err; e.chk_rd = chk_rd; e.rdy_cyc = cyc + 1 + ws;
        sb_q.push_back(e);
        @(negedge clk);
        req_s = 1'b0;
        we_s = 1'($urandom); size_s = 2'($urandom); uns_s = 1'($urandom);
        adr_s = $urandom; wd_s = $urandom;
        check_eq("busy_after_accept", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] adr, input logic [31:0] wd);
        do_req(1'b1, size, 1'b0, adr, wd, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] adr,
                      input logic [31:0] exp_rd);
        do_req(1'b0, size, uns, adr, 32'h0, 1'b0, 1'b1, exp_rd);
    endtask

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic u);
        logic [31:0] s;
        s = w >> (8 * lane);
        case (sz)
            2'b00:   return u ? (s & 32'h0000_00FF) : {{24{s[7]}}, s[7:0]};
            2'b01:   return u ? (s & 32'h0000_FFFF) : {{16{s[15]}}, s[15:0]};
            2'b10:   return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mdl_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] mask;
        int          sh;
        case (sz)
            2'b00:   begin sh = 8 * lane;       mask = 32'h0000_00FF << sh; end
            2'b01:   begin sh = 16 * lane[1];   mask = 32'h0000_FFFF << sh; end
            default: begin sh = 0;              mask = 32'hFFFF_FFFF;       end
        endcase
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    logic [31:0] mdl [8];
    logic [1:0]  e_size [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] e_adr  [4] = '{32'h21, 32'h22, 32'h20, 32'(DEPTH * 4)};
    logic        e_we   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int t0;
        reset = 1'b0; sel = 1'b0; ws = 2;
        req_s = 1'b0; we_s = 1'b0; size_s = 2'b00; uns_s = 1'b0; adr_s = 32'h0; wd_s = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_ws2", bus2.rd, 32'h0);
        check_eq("rst_flags_ws2", {29'd0, bus2.ready, bus2.err, bus2.busy}, 32'h0);
        check_eq("rst_rd_ws0", bus0.rd, 32'h0);
        check_eq("rst_flags_ws0", {29'd0, bus0.ready, bus0.err, bus0.busy}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Basic word, byte and half traffic.
        st(2'b10, 32'h10, 32'hDEADBEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        st(2'b10, 32'h10, 32'h11223344);
        st(2'b00, 32'h13, 32'h0000_0080);
        ld(2'b00, 1'b0, 32'h13, 32'hFFFFFF80);
        ld(2'b00, 1'b1, 32'h13, 32'h00000080);
        ld(2'b10, 1'b0, 32'h10, 32'h80223344);
        ld(2'b01, 1'b0, 32'h12, 32'hFFFF8022);
        ld(2'b01, 1'b1, 32'h10, 32'h00003344);
        ld(2'b00, 1'b0, 32'h11, 32'h00000033);
        st(2'b01, 32'h12, 32'h0000A5A5);
        ld(2'b10, 1'b0, 32'h10, 32'hA5A53344);

        // Error cases, each followed by a reload proving memory is untouched.
        st(2'b10, 32'h20, 32'h55667788);
        for (int i = 0; i < 4; i++) begin
            do_req(e_we[i], e_size[i], 1'b0, e_adr[i], 32'hAAAAAAAA, 1'b1, 1'b1, 32'h0);
            ld(2'b10, 1'b0, 32'h20, 32'h55667788);
        end

        // req held high: exactly WAIT_STATES+2 cycles between acceptances.
        wait_idle();
        req_s = 1'b1; we_s = 1'b0; size_s = 2'b10; uns_s = 1'b0; adr_s = 32'h10; wd_s = 32'h0;
        t0 = cyc;
        for (int k = 0; k < 3; k++) sb_q.push_back('{32'hA5A53344, 1'b0, 1'b1, t0 + 3 + 4 * k});
        repeat (11) @(negedge clk);
        req_s = 1'b0;

        // Reset during WAIT of a store discards it and clears outputs.
        st(2'b10, 32'h30, 32'h0);
        ld(2'b10, 1'b0, 32'h10, 32'hA5A53344);
        wait_idle();
        req_s = 1'b1; we_s = 1'b1; size_s = 2'b10; adr_s = 32'h30; wd_s = 32'h12345678;
        @(negedge clk);
        req_s = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_wait_rd", rd_o, 32'h0);
        check_eq("rst_wait_flags", {29'd0, rdy_o, err_o, busy_o}, 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        ld(2'b10, 1'b0, 32'h30, 32'h0);

        // Reset and req in the same cycle: request dropped.
        wait_idle();
        reset = 1'b0;
        req_s = 1'b1; we_s = 1'b1; size_s = 2'b10; adr_s = 32'h30; wd_s = 32'hFFFFFFFF;
        @(negedge clk);
        req_s = 1'b0; reset = 1'b1;
        check_eq("rst_req_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
        ld(2'b10, 1'b0, 32'h30, 32'h0);

        // Random mix against a reference model over words 0..7.
        for (int i = 0; i < 8; i++) begin
            mdl[i] = $urandom;
            st(2'b10, 32'(4 * i), mdl[i]);
        end
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  sz;
            logic [31:0] a, w;
            logic        u, is_st, er;
            sz = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 31));
            w = $urandom; u = 1'($urandom); is_st = 1'($urandom);
            er = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
            if (is_st) begin
                do_req(1'b1, sz, u, a, w, er, er, 32'h0);
                if (!er) mdl[a[4:2]] = mdl_store(mdl[a[4:2]], w, sz, a[1:0]);
            end else begin
                do_req(1'b0, sz, u, a, w, er, 1'b1,
                       er ? 32'h0 : mdl_load(mdl[a[4:2]], sz, a[1:0], u));
            end
        end

        // Zero wait-state instance.
        wait_idle();
        sel = 1'b1; ws = 0;
        @(negedge clk);
        st(2'b01, 32'h42, 32'h0000BEEF);
        ld(2'b01, 1'b0, 32'h42, 32'hFFFFBEEF);
        ld(2'b01, 1'b1, 32'h42, 32'h0000BEEF);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
